// File: rtl/assign_chain_pkg.sv
// Shared types and constants for the assign-chain engine.
package assign_chain_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] STEP_A = 2'd0;
  localparam logic [1:0] STEP_D = 2'd1;
  localparam logic [1:0] STEP_B = 2'd2;
  localparam logic [1:0] STEP_C = 2'd3;

  localparam int DEF_SUB_K = 3;
  localparam int DEF_ADD_K = 10;

endpackage

// File: rtl/assign_chain_alu.sv
// Combinational next-value logic for the chain a=b+c, d=a-SUB_K, b=d+ADD_K, c=c+1.
// PARALLEL=1 applies all four updates from the old values at once.
module assign_chain_alu
  import assign_chain_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SUB_K    = DEF_SUB_K,
  parameter int ADD_K    = DEF_ADD_K,
  parameter bit PARALLEL = 1'b0
) (
  input  logic [1:0]              sel_i,
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  input  logic signed [WIDTH-1:0] c_i,
  input  logic signed [WIDTH-1:0] d_i,
  output logic signed [WIDTH-1:0] a_o,
  output logic signed [WIDTH-1:0] b_o,
  output logic signed [WIDTH-1:0] c_o,
  output logic signed [WIDTH-1:0] d_o
);

  localparam logic signed [WIDTH-1:0] SUB_V = WIDTH'(SUB_K);
  localparam logic signed [WIDTH-1:0] ADD_V = WIDTH'(ADD_K);
  localparam logic signed [WIDTH-1:0] ONE_V = WIDTH'(1);

  logic signed [WIDTH-1:0] a_new, b_new, c_new, d_new;

  // All arithmetic wraps modulo 2^WIDTH.
  always_comb begin
    a_new = b_i + c_i;
    d_new = a_i - SUB_V;
    b_new = d_i + ADD_V;
    c_new = c_i + ONE_V;
  end

  always_comb begin
    a_o = a_i;
    b_o = b_i;
    c_o = c_i;
    d_o = d_i;
    if (PARALLEL) begin
      a_o = a_new;
      b_o = b_new;
      c_o = c_new;
      d_o = d_new;
    end else begin
      case (sel_i)
        STEP_A:  a_o = a_new;
        STEP_D:  d_o = d_new;
        STEP_B:  b_o = b_new;
        default: c_o = c_new;
      endcase
    end
  end

endmodule

// File: rtl/assign_chain_engine.sv
// Clocked assign-chain engine: one update per EXEC, each result published on a valid/ready stream.
// Define ASSIGN_CHAIN_PARALLEL_EN to update all four registers per EXEC (one result per round).
module assign_chain_engine
  import assign_chain_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ROUNDS = 4,
  parameter int SUB_K  = DEF_SUB_K,
  parameter int ADD_K  = DEF_ADD_K,
  localparam int RW    = $clog2(ROUNDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] c_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             busy,
  output logic             step_valid,
  input  logic             step_ready,
  output logic [1:0]       step_idx,
  output logic [RW-1:0]    round_idx,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] c_out,
  output logic [WIDTH-1:0] d_out,
  output logic             done
);

`ifdef ASSIGN_CHAIN_PARALLEL_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  localparam logic [RW-1:0] LAST_R = RW'(ROUNDS - 1);

  state_t                  state_q;
  logic signed [WIDTH-1:0] a_q, b_q, c_q, d_q;
  logic signed [WIDTH-1:0] a_d, b_d, c_d, d_d;
  logic [1:0]              step_q;
  logic [RW-1:0]           round_q;
  logic                    valid_q, busy_q, done_q;
  logic                    last_step;

  assign last_step = (step_q == STEP_C) && (round_q == LAST_R);

  assign_chain_alu #(
    .WIDTH   (WIDTH),
    .SUB_K   (SUB_K),
    .ADD_K   (ADD_K),
    .PARALLEL(PAR)
  ) u_alu (
    .sel_i(step_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .c_i  (c_q),
    .d_i  (d_q),
    .a_o  (a_d),
    .b_o  (b_d),
    .c_o  (c_d),
    .d_o  (d_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      step_q  <= STEP_A;
      round_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Only IDLE looks at start, so a start during a run is dropped.
          if (start) begin
            a_q     <= a_in;
            b_q     <= b_in;
            c_q     <= c_in;
            d_q     <= d_in;
            step_q  <= STEP_A;
            round_q <= '0;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          a_q     <= a_d;
          b_q     <= b_d;
          c_q     <= c_d;
          d_q     <= d_d;
          if (PAR) step_q <= STEP_C;
          valid_q <= 1'b1;
          state_q <= HOLD;
        end
        HOLD: begin
          if (step_ready) begin
            valid_q <= 1'b0;
            if (last_step) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              if (!PAR) step_q <= step_q + 2'd1;
              if (step_q == STEP_C) round_q <= round_q + RW'(1);
              state_q <= EXEC;
            end
          end
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign step_valid = valid_q;
  assign step_idx   = step_q;
  assign round_idx  = round_q;
  assign a_out      = a_q;
  assign b_out      = b_q;
  assign c_out      = c_q;
  assign d_out      = d_q;
  assign done       = done_q;

endmodule
